// File: rtl/natv_bus_demux.sv
// Native-bus address demultiplexer: decodes one core request, forwards it to one slave
// and returns the response. Optional slave-response timeout: define NATV_BUS_TIMEOUT_EN.
module natv_bus_demux #(
    parameter int                    NUM_SLV     = 4,
    // Slave 0 occupies the low 32-bit word of the packed vectors.
    parameter logic [NUM_SLV*32-1:0] SLV_BASE    = {32'h3000_0000, 32'h2000_0000,
                                                    32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*32-1:0] SLV_MASK    = {4{32'hF000_0000}},
    parameter logic [31:0]           DEF_RDATA   = 32'hDEAD_BEEF,
    parameter int                    TIMEOUT_CYC = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  core_valid_i,
    input  logic [31:0]           core_addr_i,
    input  logic [31:0]           core_wdata_i,
    input  logic [3:0]            core_wstrb_i,
    output logic [31:0]           core_rdata_o,
    output logic                  core_ready_o,
    output logic [NUM_SLV-1:0]    slv_valid_o,
    output logic [31:0]           slv_addr_o,
    output logic [31:0]           slv_wdata_o,
    output logic [3:0]            slv_wstrb_o,
    input  logic [NUM_SLV*32-1:0] slv_rdata_i,
    input  logic [NUM_SLV-1:0]    slv_ready_i,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    if (NUM_SLV < 1 || NUM_SLV > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("natv_bus_demux: unsupported NUM_SLV or TIMEOUT_CYC");
    end

    state_t               state_q, state_d;
    logic [NUM_SLV-1:0]   sel_q, sel_d;
    logic [NUM_SLV-1:0]   slv_valid_q, slv_valid_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;

`ifdef NATV_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    logic [NUM_SLV-1:0]   hit;
    logic [NUM_SLV-1:0]   sel_first;
    logic [31:0]          rd_term [NUM_SLV];
    logic [31:0]          sel_rdata;
    logic                 sel_ready;

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
        assign hit[gi]     = ((core_addr_i & SLV_MASK[gi*32 +: 32]) ==
                              (SLV_BASE[gi*32 +: 32] & SLV_MASK[gi*32 +: 32]));
        assign rd_term[gi] = sel_q[gi] ? slv_rdata_i[gi*32 +: 32] : 32'h0;
    end

    // Isolating the lowest set bit makes overlapping windows resolve to the lowest index.
    assign sel_first = hit & (~hit + NUM_SLV'(1));
    assign sel_ready = |(slv_ready_i & sel_q);

    always_comb begin
        sel_rdata = 32'h0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_rdata = sel_rdata | rd_term[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        slv_valid_d = slv_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
`ifdef NATV_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef NATV_BUS_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (core_valid_i) begin
                    addr_d  = core_addr_i;
                    wdata_d = core_wdata_i;
                    wstrb_d = core_wstrb_i;
                    sel_d   = sel_first;
                    if (|hit) begin
                        slv_valid_d = sel_first;
                        state_d     = ACCESS;
                    end else begin
                        rdata_d = DEF_RDATA;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    rdata_d     = sel_rdata;
                    slv_valid_d = '0;
                    ready_d     = 1'b1;
                    state_d     = RESP;
                end
`ifdef NATV_BUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d     = DEF_RDATA;
                    slv_valid_d = '0;
                    ready_d     = 1'b1;
                    err_d       = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                slv_valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            slv_valid_q <= '0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            rdata_q     <= 32'h0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef NATV_BUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            slv_valid_q <= slv_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
`ifdef NATV_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign core_rdata_o = rdata_q;
    assign core_ready_o = ready_q;
    assign slv_valid_o  = slv_valid_q;
    assign slv_addr_o   = addr_q;
    assign slv_wdata_o  = wdata_q;
    assign slv_wstrb_o  = wstrb_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_natv_bus_demux.sv
// Randomized self-checking bench for natv_bus_demux against an address-window model;
// a second instance with overlapping windows checks lowest-index priority.
module tb_natv_bus_demux;

    localparam logic [31:0] DEF = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         core_valid;
    logic [31:0]  core_addr;
    logic [31:0]  core_wdata;
    logic [3:0]   core_wstrb;
    logic [31:0]  core_rdata;
    logic         core_ready;
    logic [3:0]   slv_valid;
    logic [31:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [3:0]   slv_wstrb;
    logic [127:0] slv_rdata;
    logic [3:0]   slv_ready;
    logic         err;

    logic         ovl_valid;
    logic [31:0]  ovl_rdata;
    logic         ovl_ready;
    logic [3:0]   ovl_slv_valid;
    logic [31:0]  ovl_slv_addr;
    logic [31:0]  ovl_slv_wdata;
    logic [3:0]   ovl_slv_wstrb;
    logic [3:0]   ovl_slv_ready;
    logic         ovl_err;

    int errors = 0;
    int checks = 0;

    // Reference address map: slave i owns the 256 MB region whose top nibble is i.
    logic [31:0] base_m [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    logic [31:0] mask_m [4] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    always #5 clk = ~clk;

    natv_bus_demux u_dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .core_valid_i (core_valid),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_wstrb_i (core_wstrb),
        .core_rdata_o (core_rdata),
        .core_ready_o (core_ready),
        .slv_valid_o  (slv_valid),
        .slv_addr_o   (slv_addr),
        .slv_wdata_o  (slv_wdata),
        .slv_wstrb_o  (slv_wstrb),
        .slv_rdata_i  (slv_rdata),
        .slv_ready_i  (slv_ready),
        .err_o        (err)
    );

    // Slave 2 matches every address (base 0, mask 0) and overlaps slave 0.
    natv_bus_demux #(
        .SLV_BASE ({32'h3000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK ({32'hF000_0000, 32'h0000_0000, 32'hF000_0000, 32'hF000_0000})
    ) u_ovl (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .core_valid_i (ovl_valid),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_wstrb_i (core_wstrb),
        .core_rdata_o (ovl_rdata),
        .core_ready_o (ovl_ready),
        .slv_valid_o  (ovl_slv_valid),
        .slv_addr_o   (ovl_slv_addr),
        .slv_wdata_o  (ovl_slv_wdata),
        .slv_wstrb_o  (ovl_slv_wstrb),
        .slv_rdata_i  ({32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000}),
        .slv_ready_i  (ovl_slv_ready),
        .err_o        (ovl_err)
    );

    assign ovl_slv_ready = ovl_slv_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & mask_m[i]) == (base_m[i] & mask_m[i])) return i;
        end
        return -1;
    endfunction

    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int waits, input logic [31:0] rd);
        int         s;
        logic [3:0] onehot;
        s = decode(a);
        $display("txn addr=%h wdata=%h wstrb=%b waits=%0d slave=%0d", a, wd, ws, waits, s);
        core_valid = 1'b1;
        core_addr  = a;
        core_wdata = wd;
        core_wstrb = ws;
        tick;
        if (s < 0) begin
            chk("miss_ready", 32'(core_ready), 32'd1);
            chk("miss_err", 32'(err), 32'd1);
            chk("miss_rdata", core_rdata, DEF);
            chk("miss_slv_valid", 32'(slv_valid), 32'd0);
            core_valid = 1'b0;
            tick;
            chk("miss_ready_off", 32'(core_ready), 32'd0);
            chk("miss_err_off", 32'(err), 32'd0);
            chk("miss_rdata_hold", core_rdata, DEF);
        end else begin
            onehot = 4'(1 << s);
            if ($urandom_range(0, 1) == 1) core_valid = 1'b0;
            for (int w = 0; w <= waits; w++) begin
                chk("acc_slv_valid", 32'(slv_valid), 32'(onehot));
                chk("acc_addr", slv_addr, a);
                chk("acc_wdata", slv_wdata, wd);
                chk("acc_wstrb", 32'(slv_wstrb), 32'(ws));
                chk("acc_ready", 32'(core_ready), 32'd0);
                chk("acc_err", 32'(err), 32'd0);
                slv_rdata = {$urandom, $urandom, $urandom, $urandom};
                slv_ready = 4'($urandom) & ~onehot;
                if (w == waits) begin
                    slv_ready = slv_ready | onehot;
                    slv_rdata[s*32 +: 32] = rd;
                end
                tick;
            end
            chk("resp_ready", 32'(core_ready), 32'd1);
            chk("resp_rdata", core_rdata, rd);
            chk("resp_err", 32'(err), 32'd0);
            chk("resp_slv_valid", 32'(slv_valid), 32'd0);
            core_valid = 1'b0;
            slv_ready  = 4'($urandom);
            tick;
            slv_ready = 4'h0;
            chk("idle_ready", 32'(core_ready), 32'd0);
            chk("idle_rdata_hold", core_rdata, rd);
            chk("idle_slv_valid", 32'(slv_valid), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(core_ready), 32'd0);
        chk({tag, "_rdata"}, core_rdata, 32'd0);
        chk({tag, "_slv_valid"}, 32'(slv_valid), 32'd0);
        chk({tag, "_addr"}, slv_addr, 32'd0);
        chk({tag, "_wdata"}, slv_wdata, 32'd0);
        chk({tag, "_wstrb"}, 32'(slv_wstrb), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  ws;
        rst_n      = 1'b0;
        core_valid = 1'b0;
        ovl_valid  = 1'b0;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        core_wstrb = 4'h0;
        slv_rdata  = '0;
        slv_ready  = 4'h0;
        repeat (3) tick;
        chk_reset_outputs("rst");
        chk("rst_ovl_valid", 32'(ovl_slv_valid), 32'd0);
        chk("rst_ovl_ready", 32'(ovl_ready), 32'd0);
        rst_n = 1'b1;
        tick;

        txn(32'h1000_0010, 32'h0, 4'b0000, 0, 32'hA5A5_0001);
        txn(32'h3000_0004, 32'h1234_5678, 4'b0011, 3, 32'h0BAD_F00D);
        txn(32'h8000_0000, 32'h0, 4'b0000, 0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            a  = $urandom;
            a[31:28] = 4'($urandom_range(0, 4));
            if (a[31:28] == 4'd4) a[31:28] = 4'($urandom_range(4, 15));
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            txn(a, $urandom, ws, $urandom_range(0, 4), $urandom);
        end

        $display("txn overlap addr=00000000");
        core_addr = 32'h0;
        ovl_valid = 1'b1;
        tick;
        chk("ovl_slv_valid", 32'(ovl_slv_valid), 32'h1);
        ovl_valid = 1'b0;
        tick;
        chk("ovl_ready", 32'(ovl_ready), 32'd1);
        chk("ovl_rdata", ovl_rdata, 32'hC000_0000);
        chk("ovl_err", 32'(ovl_err), 32'd0);
        tick;

        $display("txn overlap addr=80000000");
        core_addr = 32'h8000_0000;
        ovl_valid = 1'b1;
        tick;
        chk("ovl_catchall_valid", 32'(ovl_slv_valid), 32'h4);
        ovl_valid = 1'b0;
        tick;
        chk("ovl_catchall_rdata", ovl_rdata, 32'hC000_0002);
        chk("ovl_catchall_err", 32'(ovl_err), 32'd0);
        tick;

        $display("txn reset-abort addr=20000000");
        core_valid = 1'b1;
        core_addr  = 32'h2000_0000;
        core_wdata = 32'h5555_AAAA;
        core_wstrb = 4'b1111;
        tick;
        chk("stall_slv_valid", 32'(slv_valid), 32'h4);
        tick;
        tick;
        chk("stall_held", 32'(slv_valid), 32'h4);
        chk("stall_no_ready", 32'(core_ready), 32'd0);
        rst_n      = 1'b0;
        core_valid = 1'b0;
        tick;
        chk_reset_outputs("abort");
        rst_n = 1'b1;
        tick;
        chk("abort_idle_valid", 32'(slv_valid), 32'd0);
        txn(32'h0000_0040, 32'h0, 4'b0000, 1, 32'h600D_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
